enc_codeword_gen_serial: RTL and testbench

- Bit-serial SECDED Hamming encoder. It is the transmit-side counterpart of the decoder syndrome multipliers.
- Accepts a data word over a valid/ready handshake and produces an 8-, 16- or 32-bit codeword selected by codeword_width.
- The codeword layout is the one the decoder syndrome check expects: 4/5/6 check bits.
- Trades latency for area. One data bit is processed per clock.

---
 rtl/enc_codeword_gen_serial.sv | 184 ++++++++++++++++++
 tb/tb_enc_codeword_gen_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_codeword_gen_serial.sv
// enc_codeword_gen_serial -- bit-serial SECDED Hamming encoder.
//
// Takes one data word over a valid/ready handshake and emits an 8-, 16- or
// 32-bit SECDED codeword. One data bit is consumed per clock. The result is
// held on codeword_out until the downstream stage accepts it.
//
// Codeword layout (N = 8/16/32):
//   bit i is Hamming position i; check bits sit at positions 1,2,4,8,16
//   (those below N); data bits fill the remaining positions in ascending
//   order starting with data_in[0] at position 3. The check bit at
//   position 2^j is bit j of S, where S is the XOR of the positions of all
//   set data bits. Bit 0 is the overall parity of bits 1..N-1.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   in_valid       data_in / codeword_width valid
//   in_ready       block can accept a word (IDLE only)
//   data_in        data bits, LSB-aligned; only the low K bits are used
//   codeword_width 00 = 8-bit (K=4), 01 = 16-bit (K=11), 1x = 32-bit (K=26)
//   err_mask       (ENC_ERR_INJECT_EN only) bits XORed into the codeword
//   out_valid      codeword_out valid
//   out_ready      downstream accepts the codeword
//   codeword_out   encoded word; bits at or above the selected width are 0
//   busy           high while a word is being encoded or waiting for pickup
//
// Optional feature: define ENC_ERR_INJECT_EN to add the err_mask input.
// The mask is captured with the data word and XORed (width-limited) into
// the codeword, which lets a decoder bench see 1- and 2-bit errors.

module enc_codeword_gen_serial #(
   parameter int MAX_DATA_W = 26,
   parameter int CW_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MAX_DATA_W-1:0] data_in,
   input  logic [1:0]            codeword_width,
`ifdef ENC_ERR_INJECT_EN
   input  logic [CW_W-1:0]       err_mask,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW_W-1:0]       codeword_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state, state_nxt;
   logic                  accept, last;

   logic [MAX_DATA_W-1:0] data_sr;    // data word, shifted right one bit per CALC cycle
   logic [4:0]            k_cnt;      // index of the data bit being handled
   logic [4:0]            k_last;     // K-1 for the captured width
   logic [4:0]            pos;        // Hamming position of the current data bit
   logic [4:0]            syn;        // running S
   logic                  par;        // running parity of the data bits
   logic [CW_W-1:0]       acc;        // data bits placed at their positions
   logic [CW_W-1:0]       wmask;      // ones below the selected width
`ifdef ENC_ERR_INJECT_EN
   logic [CW_W-1:0]       emask;
`endif

   logic                  bit_cur;
   logic [4:0]            syn_nxt;
   logic                  par_nxt;
   logic [CW_W-1:0]       acc_nxt;
   logic [4:0]            pos_inc;
   logic [4:0]            pos_nxt;
   logic [CW_W-1:0]       cw_nxt;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (k_cnt == k_last) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_comb begin
      bit_cur      = data_sr[0];
      syn_nxt      = bit_cur ? (syn ^ pos) : syn;
      par_nxt      = par ^ bit_cur;
      acc_nxt      = acc;
      acc_nxt[pos] = bit_cur;
      // Step to the next position that is not a power of two (skip check slots).
      pos_inc      = pos + 5'd1;
      pos_nxt      = ((pos_inc & (pos_inc - 5'd1)) == 5'd0) ? (pos + 5'd2) : pos_inc;

      // Final codeword from the post-update S/P so the last data bit counts.
      // Check-bit slots in acc are still zero, so plain assignment is safe.
      cw_nxt = acc_nxt;
      for (int j = 0; j < 5; j++) cw_nxt[1 << j] = syn_nxt[j];
      // Check bits contribute XOR-reduce(S) ones, data bits contribute P.
      cw_nxt[0] = par_nxt ^ (^syn_nxt);
      cw_nxt    = cw_nxt & wmask;
`ifdef ENC_ERR_INJECT_EN
      cw_nxt    = cw_nxt ^ (emask & wmask);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_sr      <= '0;
         k_cnt        <= '0;
         k_last       <= '0;
         pos          <= '0;
         syn          <= '0;
         par          <= 1'b0;
         acc          <= '0;
         wmask        <= '0;
         codeword_out <= '0;
`ifdef ENC_ERR_INJECT_EN
         emask        <= '0;
`endif
      end else if (accept) begin
         data_sr <= data_in;
         k_cnt   <= '0;
         pos     <= 5'd3;
         syn     <= '0;
         par     <= 1'b0;
         acc     <= '0;
         case (codeword_width)
            2'b00: begin
               k_last <= 5'd3;
               wmask  <= CW_W'(32'h0000_00FF);
            end
            2'b01: begin
               k_last <= 5'd10;
               wmask  <= CW_W'(32'h0000_FFFF);
            end
            default: begin   // 10 and 11 both select 32 bits
               k_last <= 5'd25;
               wmask  <= '1;
            end
         endcase
`ifdef ENC_ERR_INJECT_EN
         emask   <= err_mask;
`endif
      end else if (state == CALC) begin
         data_sr <= data_sr >> 1;
         k_cnt   <= k_cnt + 5'd1;
         pos     <= pos_nxt;
         syn     <= syn_nxt;
         par     <= par_nxt;
         acc     <= acc_nxt;
         if (last) codeword_out <= cw_nxt;
      end
   end

endmodule

// File: tb/tb_enc_codeword_gen_serial.sv
// Self-checking bench for enc_codeword_gen_serial: directed vectors, a
// mid-operation reset, and random words checked against a position-by-
// position Hamming reference model. Define ENC_ERR_INJECT_EN for both the
// design and this bench to exercise the error-injection path.

module tb_enc_codeword_gen_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [25:0] data_in = '0;
   logic [1:0]  codeword_width = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] codeword_out;
   logic        busy;
`ifdef ENC_ERR_INJECT_EN
   logic [31:0] err_mask = '0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   enc_codeword_gen_serial dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .data_in        (data_in),
      .codeword_width (codeword_width),
`ifdef ENC_ERR_INJECT_EN
      .err_mask       (err_mask),
`endif
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .codeword_out   (codeword_out),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int n_of(input logic [1:0] w);
      return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
   endfunction

   function automatic int k_of(input logic [1:0] w);
      return (w == 2'b00) ? 4 : (w == 2'b01) ? 11 : 26;
   endfunction

   function automatic logic [31:0] wmask_of(input logic [1:0] w);
      return (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   // Reference: walk positions 1..N-1, hand out data bits to non-powers of
   // two, XOR set positions into S, then fill check slots and overall parity.
   function automatic logic [31:0] ref_cw(input logic [25:0] d, input logic [1:0] w);
      int          n = n_of(w);
      int          k = 0;
      int          s = 0;
      logic [31:0] cw = '0;
      for (int p = 1; p < n; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (d[k]) begin
               cw[p] = 1'b1;
               s     = s ^ p;
            end
            k++;
         end
      end
      for (int j = 0; j < 5; j++)
         if ((1 << j) < n && ((s >> j) & 1) == 1) cw[1 << j] = 1'b1;
      cw[0] = ^cw[31:1];
      return cw;
   endfunction

   // One full transaction: accept, measure latency, check value, hold
   // out_ready low for 'hold' cycles, then release and check return to IDLE.
   task automatic run_word(input logic [25:0] d, input logic [1:0] w,
                           input logic [31:0] mask, input int hold,
                           input logic [31:0] exp);
      int lat;
      @(negedge clk);
      check("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid       = 1'b1;
      data_in        = d;
      codeword_width = w;
`ifdef ENC_ERR_INJECT_EN
      err_mask       = mask;
`endif
      @(posedge clk); #1;
      // Scribble inputs after acceptance; in_valid stays high while busy and
      // out_ready is high early in CALC -- all of this must be ignored.
      data_in        = 26'($urandom);
      codeword_width = 2'($urandom);
`ifdef ENC_ERR_INJECT_EN
      err_mask       = $urandom;
`endif
      out_ready      = 1'b1;
      check("busy_calc", {31'b0, busy}, 32'd1);
      check("in_ready_calc", {31'b0, in_ready}, 32'd0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) out_ready = 1'b0;
      end
      in_valid = 1'b0;
      check("latency", 32'(lat), 32'(k_of(w)));
      check("codeword", codeword_out, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_codeword", codeword_out, exp);
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", {31'b0, out_valid}, 32'd0);
      check("in_ready_back", {31'b0, in_ready}, 32'd1);
      check("busy_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [25:0] d;
      logic [1:0]  w;
      logic [31:0] m;
      logic [31:0] e;

      // Reset state
      #1 rst = 1'b0;
      #11;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_codeword", codeword_out, 32'd0);
      @(negedge clk) rst = 1'b1;

      // Directed vectors
      run_word(26'h000000B, 2'b00, 32'h0, 5, 32'h0000_00AA);
      run_word(26'h000000F, 2'b00, 32'h0, 1, 32'h0000_00FF);
      run_word(26'h0000000, 2'b00, 32'h0, 1, 32'h0000_0000);
      run_word(26'h0000001, 2'b01, 32'h0, 1, 32'h0000_000F);
      run_word(26'h2000000, 2'b10, 32'h0, 1, 32'h8001_0116);
      run_word(26'h2000000, 2'b11, 32'h0, 1, 32'h8001_0116);

      // Reset in the middle of a 32-bit word
      @(negedge clk);
      in_valid       = 1'b1;
      data_in        = 26'h3FF_FFFF;
      codeword_width = 2'b10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_codeword", codeword_out, 32'd0);
      @(negedge clk) rst = 1'b1;
      d = 26'($urandom);
      run_word(d, 2'b10, 32'h0, 1, ref_cw(d, 2'b10));

      // Random words against the reference model
      for (int i = 0; i < 16; i++) begin
         d = 26'($urandom);
         w = 2'($urandom);
         m = 32'h0;
         e = ref_cw(d, w);
         run_word(d, w, m, $urandom_range(0, 3), e);
      end

`ifdef ENC_ERR_INJECT_EN
      run_word(26'h000000B, 2'b00, 32'h0000_0101, 1, 32'h0000_00AB);
      for (int i = 0; i < 8; i++) begin
         d = 26'($urandom);
         w = 2'($urandom);
         m = 32'h1 << $urandom_range(0, 31);
         if ((i & 1) == 1) m = m | (32'h1 << $urandom_range(0, 31));
         e = ref_cw(d, w) ^ (m & wmask_of(w));
         run_word(d, w, m, 1, e);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
